// File: rtl/mem_stage_dual.sv
// Dual-slot MEM stage: single-ported data RAM, slot 1 then slot 2 in program order, one stall cycle on conflict.
// Optional MEM_ALIGN_CHECK_EN: misaligned accesses drop their write and raise sticky misalign_err.
module mem_stage_dual #(
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] alu_result_1,
  input  logic [31:0] alu_result_2,
  input  logic [31:0] writedata_1,
  input  logic [31:0] writedata_2,
  input  logic [4:0]  rd_1,
  input  logic [4:0]  rd_2,
  input  logic        memread1,
  input  logic        memread2,
  input  logic        memwrite1,
  input  logic        memwrite2,
  input  logic        memtoreg1,
  input  logic        memtoreg2,
  input  logic        regwrite1,
  input  logic        regwrite2,
  output logic        stall,
  output logic [31:0] wb_result_1,
  output logic [31:0] wb_result_2,
  output logic [31:0] wb_readdata_1,
  output logic [31:0] wb_readdata_2,
  output logic [4:0]  wb_rd_1,
  output logic [4:0]  wb_rd_2,
  output logic        wb_memtoreg1,
  output logic        wb_memtoreg2,
  output logic        wb_regwrite1,
  output logic        wb_regwrite2,
  output logic        misalign_err,
  output logic        dbg_state
);
  // Handshake: no valid/ready; stall=1 means upstream must hold its slot pair unchanged for one more cycle.
  typedef enum logic {IDLE = 1'b0, SECOND = 1'b1} state_t;

  state_t state_q, state_d;
  logic [31:0] ram_q [2**ADDR_W];
  logic [31:0] hold_q, hold_d;
  logic        misalign_q, misalign_d;
  logic [31:0] wb_result_1_q, wb_result_1_d, wb_result_2_q, wb_result_2_d;
  logic [31:0] wb_readdata_1_q, wb_readdata_1_d, wb_readdata_2_q, wb_readdata_2_d;
  logic [4:0]  wb_rd_1_q, wb_rd_1_d, wb_rd_2_q, wb_rd_2_d;
  logic        wb_memtoreg1_q, wb_memtoreg1_d, wb_memtoreg2_q, wb_memtoreg2_d;
  logic        wb_regwrite1_q, wb_regwrite1_d, wb_regwrite2_q, wb_regwrite2_d;

  logic              mem1, mem2, mis1, mis2;
  logic [ADDR_W-1:0] idx1, idx2, waddr;
  logic [31:0]       rdata1, rdata2, wdata;
  logic              we;
  logic              unused_addr_bits;

  assign mem1   = memread1 | memwrite1;
  assign mem2   = memread2 | memwrite2;
  assign idx1   = alu_result_1[ADDR_W+1:2];
  assign idx2   = alu_result_2[ADDR_W+1:2];
  assign rdata1 = ram_q[idx1];
  assign rdata2 = ram_q[idx2];
  assign unused_addr_bits = ^{alu_result_1[31:ADDR_W+2], alu_result_1[1:0],
                              alu_result_2[31:ADDR_W+2], alu_result_2[1:0]};

`ifdef MEM_ALIGN_CHECK_EN
  assign mis1 = mem1 && (alu_result_1[1:0] != 2'b00);
  assign mis2 = mem2 && (alu_result_2[1:0] != 2'b00);
`else
  assign mis1 = 1'b0;
  assign mis2 = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      hold_q          <= '0;
      misalign_q      <= 1'b0;
      wb_result_1_q   <= '0;
      wb_result_2_q   <= '0;
      wb_readdata_1_q <= '0;
      wb_readdata_2_q <= '0;
      wb_rd_1_q       <= '0;
      wb_rd_2_q       <= '0;
      wb_memtoreg1_q  <= 1'b0;
      wb_memtoreg2_q  <= 1'b0;
      wb_regwrite1_q  <= 1'b0;
      wb_regwrite2_q  <= 1'b0;
    end else begin
      state_q         <= state_d;
      hold_q          <= hold_d;
      misalign_q      <= misalign_d;
      wb_result_1_q   <= wb_result_1_d;
      wb_result_2_q   <= wb_result_2_d;
      wb_readdata_1_q <= wb_readdata_1_d;
      wb_readdata_2_q <= wb_readdata_2_d;
      wb_rd_1_q       <= wb_rd_1_d;
      wb_rd_2_q       <= wb_rd_2_d;
      wb_memtoreg1_q  <= wb_memtoreg1_d;
      wb_memtoreg2_q  <= wb_memtoreg2_d;
      wb_regwrite1_q  <= wb_regwrite1_d;
      wb_regwrite2_q  <= wb_regwrite2_d;
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (we) ram_q[waddr] <= wdata;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mem1 && mem2) state_d = SECOND;
      SECOND:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    we              = 1'b0;
    waddr           = idx1;
    wdata           = writedata_1;
    hold_d          = hold_q;
    misalign_d      = misalign_q;
    wb_result_1_d   = alu_result_1;
    wb_result_2_d   = alu_result_2;
    wb_readdata_1_d = rdata1;
    wb_readdata_2_d = rdata2;
    wb_rd_1_d       = rd_1;
    wb_rd_2_d       = rd_2;
    wb_memtoreg1_d  = memtoreg1;
    wb_memtoreg2_d  = memtoreg2;
    wb_regwrite1_d  = regwrite1;
    wb_regwrite2_d  = regwrite2;
    case (state_q)
      IDLE: begin
        if (mem1) begin
          we         = memwrite1 && !mis1;
          misalign_d = misalign_q | mis1;
          if (mem2) begin
            // Slot 1 goes first; its pre-write read value waits in hold for the second cycle.
            hold_d         = rdata1;
            wb_memtoreg1_d = 1'b0;
            wb_memtoreg2_d = 1'b0;
            wb_regwrite1_d = 1'b0;
            wb_regwrite2_d = 1'b0;
          end
        end else if (mem2) begin
          we         = memwrite2 && !mis2;
          waddr      = idx2;
          wdata      = writedata_2;
          misalign_d = misalign_q | mis2;
        end
      end
      SECOND: begin
        we              = memwrite2 && !mis2;
        waddr           = idx2;
        wdata           = writedata_2;
        misalign_d      = misalign_q | mis2;
        wb_readdata_1_d = hold_q;
      end
      default: ;
    endcase
  end

  assign stall         = reset && (state_q == IDLE) && mem1 && mem2;
  assign dbg_state     = (state_q == SECOND);
  assign misalign_err  = misalign_q;
  assign wb_result_1   = wb_result_1_q;
  assign wb_result_2   = wb_result_2_q;
  assign wb_readdata_1 = wb_readdata_1_q;
  assign wb_readdata_2 = wb_readdata_2_q;
  assign wb_rd_1       = wb_rd_1_q;
  assign wb_rd_2       = wb_rd_2_q;
  assign wb_memtoreg1  = wb_memtoreg1_q;
  assign wb_memtoreg2  = wb_memtoreg2_q;
  assign wb_regwrite1  = wb_regwrite1_q;
  assign wb_regwrite2  = wb_regwrite2_q;
endmodule
